// File: rtl/oam_dma_if.sv
// Bus bundle between the OAM DMA engine, the CPU snoop path and the mmu port.
// master: DMA engine side; slave: the system/top-level side.
interface oam_dma_if;
   logic [15:0] iCpuAddr;
   logic        iCpuWe;
   logic [7:0]  iCpuData;
   logic [15:0] oAddr;
   logic        oWe;
   logic [7:0]  oData;
   logic [7:0]  iData;
   logic        oBusy;
   logic        oDone;
   logic [7:0]  oRegData;

   modport master (
      input  iCpuAddr, iCpuWe, iCpuData, iData,
      output oAddr, oWe, oData, oBusy, oDone, oRegData
   );

   modport slave (
      output iCpuAddr, iCpuWe, iCpuData, iData,
      input  oAddr, oWe, oData, oBusy, oDone, oRegData
   );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to 0xFF46 copies 160 bytes from {src,8'h00} to 0xFE00.
// Optional OAM_DMA_READBACK_EN: oRegData returns the last value written to 0xFF46.
module oam_dma (
   input  logic      iClock,
   input  logic      iReset,
   oam_dma_if.master bus
);
   localparam logic [15:0] TrigAddr = 16'hFF46;
   localparam logic [15:0] OamBase  = 16'hFE00;
   localparam logic [7:0]  LastIdx  = 8'h9F;

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   state_e     state_q, state_d;
   logic [7:0] src_q, src_d;
   logic [7:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic       trigger;

   assign trigger = bus.iCpuWe && (bus.iCpuAddr == TrigAddr);

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= StIdle;
         src_q   <= 8'h00;
         idx_q   <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle:  state_d = StIdle;
         StRead:  state_d = StWrite;
         StWrite: begin
            if (idx_q == LastIdx) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = StRead;
            end
         end
         default: state_d = StIdle;
      endcase
      // A trigger always wins, abandoning any copy in flight without a done pulse.
      if (trigger) begin
         src_d   = bus.iCpuData;
         idx_d   = 8'h00;
         state_d = StRead;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      bus.oAddr = 16'h0000;
      bus.oWe   = 1'b0;
      bus.oData = 8'h00;
      bus.oBusy = 1'b0;
      unique case (state_q)
         StIdle: ;
         StRead: begin
            bus.oAddr = {src_q, idx_q};
            bus.oBusy = 1'b1;
         end
         StWrite: begin
            bus.oAddr = OamBase + {8'h00, idx_q};
            bus.oWe   = 1'b1;
            bus.oData = bus.iData;
            bus.oBusy = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.oDone = done_q;

`ifdef OAM_DMA_READBACK_EN
   assign bus.oRegData = src_q;
`else
   assign bus.oRegData = 8'hFF;
`endif
endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: behavioural mmu memory plus a write scoreboard.
module tb_oam_dma;
   logic clk;
   logic rst_n;
   oam_dma_if bus ();

   oam_dma dut (
      .iClock (clk),
      .iReset (rst_n),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous one-cycle-latency memory with a backdoor write port for preloading.
   logic [7:0]  mem [0:65535];
   logic [7:0]  rdata;
   logic        pl_we;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;

   always @(posedge clk) begin
      rdata <= mem[bus.oAddr];
      if (bus.oWe === 1'b1) mem[bus.oAddr] <= bus.oData;
      if (pl_we) mem[pl_addr] <= pl_data;
   end
   assign bus.iData = rdata;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [7:0] src, input int i);
      logic [7:0] b;
      b = i[7:0];
      if (src == 8'hC0) return b ^ 8'h5A;
      return (b ^ src) + 8'h07;
   endfunction

   task automatic fill(input logic [15:0] base, input logic [7:0] src, input bit zero);
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         pl_addr = base + 16'(i);
         pl_data = zero ? 8'h00 : pat(src, i);
         pl_we   = 1'b1;
      end
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] src);
      for (int i = 0; i < 160; i++) exp_q.push_back({16'hFE00 + 16'(i), pat(src, i)});
   endtask

   // Called just after a negedge; the posedge inside is the sampling edge T.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      bus.iCpuAddr = a;
      bus.iCpuData = d;
      bus.iCpuWe   = 1'b1;
      @(posedge clk);
      #1;
      bus.iCpuWe   = 1'b0;
      bus.iCpuAddr = 16'h0000;
      bus.iCpuData = 8'h00;
   endtask

   // Monitors cycles T+1..T+ncyc against the timing model; idle model when !active.
   task automatic run_xfer(input logic [7:0] src, input int ncyc, input bit active);
      int bad_seq, bad_busy, bad_done, i;
      logic [15:0] ea;
      logic ew, eb, ed;
      logic [23:0] e;
      bad_seq = 0; bad_busy = 0; bad_done = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         ea = 16'h0000; ew = 1'b0; eb = 1'b0; ed = 1'b0;
         if (active) begin
            if (c <= 320) begin
               eb = 1'b1;
               i  = (c - 1) / 2;
               if (c % 2 == 1) ea = {src, i[7:0]};
               else begin
                  ea = 16'hFE00 + 16'(i);
                  ew = 1'b1;
               end
            end
            ed = (c == 321);
         end
         if (bus.oAddr !== ea || bus.oWe !== ew) bad_seq++;
         if (!ew && bus.oData !== 8'h00) bad_seq++;
         if (bus.oBusy !== eb) bad_busy++;
         if (bus.oDone !== ed) bad_done++;
         if (bus.oWe === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("sb_write", {8'h00, bus.oAddr, bus.oData}, {8'h00, e});
            end
         end
      end
      chk("addr_we_seq", 32'(bad_seq), 32'd0);
      chk("busy_window", 32'(bad_busy), 32'd0);
      chk("done_pulse", 32'(bad_done), 32'd0);
   endtask

   int bad;

   initial begin
      rst_n        = 1'b0;
      pl_we        = 1'b0;
      pl_addr      = 16'h0000;
      pl_data      = 8'h00;
      bus.iCpuAddr = 16'h0000;
      bus.iCpuWe   = 1'b0;
      bus.iCpuData = 8'h00;
      #3;
      chk("rst_addr", 32'(bus.oAddr), 32'd0);
      chk("rst_ctrl", {29'd0, bus.oWe, bus.oBusy, bus.oDone}, 32'd0);
      chk("rst_data", 32'(bus.oData), 32'd0);
`ifdef OAM_DMA_READBACK_EN
      chk("rst_regdata", 32'(bus.oRegData), 32'h00);
`else
      chk("rst_regdata", 32'(bus.oRegData), 32'hFF);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      fill(16'hC000, 8'hC0, 1'b0);
      fill(16'hD000, 8'hD0, 1'b0);
      fill(16'h8000, 8'h80, 1'b0);
      fill(16'h9C00, 8'h9C, 1'b0);

      // Basic copy from 0xC000.
      push_exp(8'hC0);
      cpu_write(16'hFF46, 8'hC0);
      run_xfer(8'hC0, 330, 1'b1);
      chk("basic_q_empty", 32'(exp_q.size()), 32'd0);
      bad = 0;
      for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== pat(8'hC0, i)) bad++;
      chk("basic_oam", 32'(bad), 32'd0);

      // Address interleave from 0x8000.
      push_exp(8'h80);
      cpu_write(16'hFF46, 8'h80);
      run_xfer(8'h80, 325, 1'b1);
      chk("seq_q_empty", 32'(exp_q.size()), 32'd0);

      // Restart: second trigger on the edge ending cycle T+49.
      push_exp(8'hC0);
      cpu_write(16'hFF46, 8'hC0);
      run_xfer(8'hC0, 49, 1'b1);
      chk("restart_partial", 32'(exp_q.size()), 32'd136);
      exp_q.delete();
      push_exp(8'hD0);
      cpu_write(16'hFF46, 8'hD0);
      #1;
      chk("restart_addr", 32'(bus.oAddr), 32'hD000);
      run_xfer(8'hD0, 330, 1'b1);
      chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

      // Non-trigger address.
      cpu_write(16'hFF47, 8'hC0);
      run_xfer(8'h00, 20, 1'b0);

      // Reset in the middle of byte 80.
      fill(16'hFE00, 8'h00, 1'b1);
      push_exp(8'hC0);
      cpu_write(16'hFF46, 8'hC0);
      run_xfer(8'hC0, 161, 1'b1);
      chk("pre_reset_busy", 32'(bus.oBusy), 32'd1);
      exp_q.delete();
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_addr", 32'(bus.oAddr), 32'd0);
      chk("async_rst_ctrl", {29'd0, bus.oWe, bus.oBusy, bus.oDone}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_xfer(8'h00, 340, 1'b0);
      bad = 0;
      for (int i = 0; i < 80; i++) if (mem[16'hFE00 + 16'(i)] !== pat(8'hC0, i)) bad++;
      chk("reset_oam_written", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 80; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== 8'h00) bad++;
      chk("reset_oam_untouched", 32'(bad), 32'd0);

      // Register readback.
      push_exp(8'h9C);
      cpu_write(16'hFF46, 8'h9C);
`ifdef OAM_DMA_READBACK_EN
      chk("readback", 32'(bus.oRegData), 32'h9C);
`else
      chk("readback", 32'(bus.oRegData), 32'hFF);
`endif
      run_xfer(8'h9C, 325, 1'b1);
      chk("readback_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
